// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALUOp classes, RV32 field constants and the
// pipeline FSM state type for the ALU decode stage.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23,
    ALU_NOP    = 5'd31
  } alu_code_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MD_RUN = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Base-ISA operation selected by funct3 alone (shift-right resolves to SRL).
  function automatic alu_code_e base_code(input logic [2:0] f3);
    base_code = ALU_NOP;
    case (f3)
      F3_ADD:  base_code = ALU_ADD;
      F3_SLL:  base_code = ALU_SLL;
      F3_SLT:  base_code = ALU_SLT;
      F3_SLTU: base_code = ALU_SLTU;
      F3_XOR:  base_code = ALU_XOR;
      F3_SR:   base_code = ALU_SRL;
      F3_OR:   base_code = ALU_OR;
      F3_AND:  base_code = ALU_AND;
      default: base_code = ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decoder: instruction fields to control code,
// illegal flag and mul/div indication.
module alu_decode
  import alu_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [1:0] alu_op,
  output alu_code_e  code,
  output logic       illegal,
  output logic       is_md
);

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    code    = ALU_NOP;
    illegal = 1'b0;
    is_md   = 1'b0;
    case (alu_op)
      ALUOP_MEM:    code = ALU_ADD;
      ALUOP_BRANCH: code = ALU_SUB;
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          code = base_code(funct3);
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          code = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          code = ALU_SRA;
        end else if (funct7 == F7_MULDIV && M_EXT != 0) begin
          code  = alu_code_e'({2'b10, funct3});
          is_md = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        // Immediate forms: only the shift-right pair looks at funct7.
        if (funct3 != F3_SR)         code = base_code(funct3);
        else if (funct7 == F7_BASE)  code = ALU_SRL;
        else if (funct7 == F7_ALT)   code = ALU_SRA;
        else                         illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_pipe.sv
// Registered ALU decode stage with valid/ready handshake; mul/div ops hold
// the stage busy for MD_LATENCY cycles before being presented downstream.
module alu_decode_pipe
  import alu_pkg::*;
#(
  parameter int M_EXT      = 1,
  parameter int MD_LATENCY = 32,
  parameter int CTRL_W     = 5
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [6:0]        i_Funct7,
  input  logic [2:0]        i_Funct3,
  input  logic [1:0]        i_ALUOp,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ALUControlLines,
  output logic              o_illegal,
  output logic              o_md_start,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  state_e           state;
  logic [CNT_W-1:0] count;
  alu_code_e        code_q;
  alu_code_e        dec_code;
  logic             dec_illegal;
  logic             dec_md;
  logic             accept;

  alu_decode #(.M_EXT(M_EXT)) u_decode (
    .funct7  (i_Funct7),
    .funct3  (i_Funct3),
    .alu_op  (i_ALUOp),
    .code    (dec_code),
    .illegal (dec_illegal),
    .is_md   (dec_md)
  );

  assign o_ready           = (state == IDLE) || (state == HOLD && i_ready);
  assign accept            = i_valid && o_ready;
  assign o_ALUControlLines = CTRL_W'(code_q);

  // NOTE: non-blocking assignments for all state; a later assignment in the
  // block overrides an earlier one, which lets an accept pre-empt the hold exit.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      count      <= '0;
      code_q     <= ALU_NOP;
      o_illegal  <= 1'b0;
      o_valid    <= 1'b0;
      o_md_start <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_md_start <= 1'b0;
      case (state)
        MD_RUN: begin
          if (count == '0) begin
            state   <= HOLD;
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        HOLD: begin
          if (i_ready && !accept) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        code_q    <= dec_code;
        o_illegal <= dec_illegal;
        if (dec_md) begin
          state      <= MD_RUN;
          count      <= CNT_LOAD;
          o_busy     <= 1'b1;
          o_md_start <= 1'b1;
          o_valid    <= 1'b0;
        end else begin
          state   <= HOLD;
          o_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Bench for alu_decode_pipe: three configurations share one stimulus stream
// and are compared every cycle against a transaction-level reference model.
module tb_alu_decode_pipe;

  localparam int N = 3;
  // Configurations: {M_EXT, MD_LATENCY} = {1,4}, {1,1}, {0,32}
  int cfg_lat [N] = '{4, 1, 32};
  bit cfg_m   [N] = '{1'b1, 1'b1, 1'b0};

  logic       clk;
  logic       rst_n;
  logic       v;
  logic       rdy;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [1:0] aop;

  logic       ready_w [N];
  logic       valid_w [N];
  logic [4:0] code_w  [N];
  logic       ill_w   [N];
  logic       start_w [N];
  logic       busy_w  [N];

  int n_checks = 0;
  int n_fail   = 0;

  bit m_valid [N];
  bit m_start [N];
  bit m_ill   [N];
  int m_code  [N];
  int m_busy  [N];

  alu_decode_pipe #(.M_EXT(1), .MD_LATENCY(4), .CTRL_W(5)) dut0 (
    .i_clk(clk), .i_rstn(rst_n), .i_valid(v), .o_ready(ready_w[0]),
    .i_Funct7(f7), .i_Funct3(f3), .i_ALUOp(aop), .o_valid(valid_w[0]),
    .i_ready(rdy), .o_ALUControlLines(code_w[0]), .o_illegal(ill_w[0]),
    .o_md_start(start_w[0]), .o_busy(busy_w[0]));

  alu_decode_pipe #(.M_EXT(1), .MD_LATENCY(1), .CTRL_W(5)) dut1 (
    .i_clk(clk), .i_rstn(rst_n), .i_valid(v), .o_ready(ready_w[1]),
    .i_Funct7(f7), .i_Funct3(f3), .i_ALUOp(aop), .o_valid(valid_w[1]),
    .i_ready(rdy), .o_ALUControlLines(code_w[1]), .o_illegal(ill_w[1]),
    .o_md_start(start_w[1]), .o_busy(busy_w[1]));

  alu_decode_pipe #(.M_EXT(0), .MD_LATENCY(32), .CTRL_W(5)) dut2 (
    .i_clk(clk), .i_rstn(rst_n), .i_valid(v), .o_ready(ready_w[2]),
    .i_Funct7(f7), .i_Funct3(f3), .i_ALUOp(aop), .o_valid(valid_w[2]),
    .i_ready(rdy), .o_ALUControlLines(code_w[2]), .o_illegal(ill_w[2]),
    .o_md_start(start_w[2]), .o_busy(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Instruction-set reference: code 31 means the combination is undefined.
  task automatic ref_decode(input bit mext, input logic [6:0] rf7, input logic [2:0] rf3,
                            input logic [1:0] raop, output int code, output bit md);
    int base [8];
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    code = 31;
    md   = 1'b0;
    case (raop)
      2'b00: code = 0;
      2'b01: code = 1;
      2'b10: begin
        if (rf7 == 7'h00)                   code = base[rf3];
        else if (rf7 == 7'h20 && rf3 == 0)  code = 1;
        else if (rf7 == 7'h20 && rf3 == 5)  code = 7;
        else if (rf7 == 7'h01 && mext) begin
          code = 16 + int'(rf3);
          md   = 1'b1;
        end
      end
      default: begin
        if (rf3 != 5)         code = base[rf3];
        else if (rf7 == 7'h00) code = 6;
        else if (rf7 == 7'h20) code = 7;
      end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0;
      m_start[k] = 1'b0;
      m_ill[k]   = 1'b0;
      m_code[k]  = 31;
      m_busy[k]  = 0;
    end
  endtask

  function automatic bit exp_ready(input int k);
    return (m_busy[k] == 0) && (!m_valid[k] || rdy);
  endfunction

  task automatic compare(input int k);
    check($sformatf("ready%0d", k), 32'(ready_w[k]), 32'(rst_n ? exp_ready(k) : 1'b1));
    check($sformatf("valid%0d", k), 32'(valid_w[k]), 32'(m_valid[k]));
    check($sformatf("busy%0d", k),  32'(busy_w[k]),  32'(m_busy[k] > 0));
    check($sformatf("start%0d", k), 32'(start_w[k]), 32'(m_start[k]));
    if (m_valid[k] || !rst_n) begin
      check($sformatf("code%0d", k),    32'(code_w[k]), 32'(m_code[k]));
      check($sformatf("illegal%0d", k), 32'(ill_w[k]),  32'(m_ill[k]));
    end
  endtask

  task automatic model_step(input int k);
    int c;
    bit md;
    bit acc;
    acc = v && exp_ready(k);
    m_start[k] = 1'b0;
    if (acc) begin
      ref_decode(cfg_m[k], f7, f3, aop, c, md);
      m_code[k] = c;
      m_ill[k]  = (c == 31);
      if (md) begin
        m_busy[k]  = cfg_lat[k];
        m_start[k] = 1'b1;
        m_valid[k] = 1'b0;
      end else begin
        m_valid[k] = 1'b1;
      end
    end else if (m_busy[k] > 0) begin
      m_busy[k]--;
      if (m_busy[k] == 0) m_valid[k] = 1'b1;
    end else if (m_valid[k] && rdy) begin
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic cycle(input bit vv, input logic [6:0] ff7, input logic [2:0] ff3,
                       input logic [1:0] aa, input bit rr);
    @(negedge clk);
    v = vv; f7 = ff7; f3 = ff3; aop = aa; rdy = rr;
    #1;
    for (int k = 0; k < N; k++) compare(k);
    for (int k = 0; k < N; k++) model_step(k);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < N; k++) compare(k);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_busy;
    int n_start0;
    int n_start2;
    int valid_at;
    int code_at;
    logic [6:0] rf7;
    rst_n = 1'b1; v = 1'b0; rdy = 1'b1; f7 = '0; f3 = '0; aop = '0;
    #2;
    apply_reset();

    // SUB via R-type funct7=0100000
    cycle(1'b1, 7'h20, 3'd0, 2'b10, 1'b1);
    cycle(1'b0, 7'h00, 3'd0, 2'b00, 1'b1);

    // Back-to-back ADD, SLL, XOR with downstream always ready
    cycle(1'b1, 7'h00, 3'd0, 2'b10, 1'b1);
    cycle(1'b1, 7'h00, 3'd1, 2'b10, 1'b1);
    cycle(1'b1, 7'h00, 3'd4, 2'b10, 1'b1);
    cycle(1'b0, 7'h00, 3'd0, 2'b00, 1'b1);
    cycle(1'b0, 7'h00, 3'd0, 2'b00, 1'b1);

    // DIV: pulse, 4 busy cycles on dut0, then code 20; illegal on dut2
    cycle(1'b1, 7'h01, 3'd4, 2'b10, 1'b1);
    n_busy = 0; n_start0 = 0; n_start2 = 0; valid_at = -1; code_at = -1;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 7'h00, 3'd0, 2'b00, 1'b1);
      if (busy_w[0]) n_busy++;
      if (start_w[0]) n_start0++;
      if (start_w[2]) n_start2++;
      if (valid_w[0] && valid_at < 0) begin
        valid_at = i;
        code_at  = int'(code_w[0]);
      end
    end
    check("div_busy_cycles", n_busy, 4);
    check("div_start_pulses", n_start0, 1);
    check("div_valid_cycle", valid_at, 4);
    check("div_code", code_at, 20);
    check("nomext_start", n_start2, 0);

    // Stall in HOLD for 3 cycles while a new op waits upstream
    cycle(1'b1, 7'h00, 3'd7, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 7'h00, 3'd6, 2'b11, 1'b0);
    cycle(1'b1, 7'h00, 3'd6, 2'b11, 1'b1);
    cycle(1'b0, 7'h00, 3'd0, 2'b00, 1'b1);

    // I-type shift-right with undefined funct7 must be illegal, not X
    cycle(1'b1, 7'h7f, 3'd5, 2'b11, 1'b1);
    cycle(1'b0, 7'h00, 3'd0, 2'b00, 1'b1);

    // Reset in the middle of a mul/div run
    cycle(1'b1, 7'h01, 3'd0, 2'b10, 1'b1);
    cycle(1'b0, 7'h00, 3'd0, 2'b00, 1'b1);
    @(posedge clk);
    #2;
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 7'h00, 3'd0, 2'b00, 1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rf7 = 7'h00;
        4, 5:       rf7 = 7'h20;
        6, 7:       rf7 = 7'h01;
        default:    rf7 = 7'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, rf7, 3'($urandom), 2'($urandom),
            $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
